hdmi_framer: RTL

HDMI_FRAMER -- requirements
Module: hdmi_framer

---
 rtl/hdmi_framer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hdmi_framer.sv
// HDMI/DVI raster framer: walks the video timing, accepts pixels in active slots and
// tells the three TMDS encoders what to send (pixel, control, preamble or guard band).
module hdmi_framer #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FRONT   = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FRONT   = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BACK    = 20,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter bit HDMI_MODE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_pix_valid,
    input  logic [23:0] i_pix,
    output logic        o_pix_ready,
    output logic        o_frame_start,
    output logic [1:0]  o_dtype0,
    output logic [1:0]  o_dtype1,
    output logic [1:0]  o_dtype2,
    output logic [1:0]  o_ctl0,
    output logic [1:0]  o_ctl1,
    output logic [1:0]  o_ctl2,
    output logic [7:0]  o_data0,
    output logic [7:0]  o_data1,
    output logic [7:0]  o_data2,
    output logic [3:0]  o_aux0,
    output logic [3:0]  o_aux1,
    output logic [3:0]  o_aux2,
    output logic        o_underflow
);

    localparam int HTOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VTOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_ZERO        = HW'(0);
    localparam logic [HW-1:0] H_ONE         = HW'(1);
    localparam logic [HW-1:0] H_LAST        = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START  = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END    = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_PRE_START   = HW'(HTOTAL - 10);
    localparam logic [HW-1:0] H_GUARD_START = HW'(HTOTAL - 2);

    localparam logic [VW-1:0] V_ZERO        = VW'(0);
    localparam logic [VW-1:0] V_ONE         = VW'(1);
    localparam logic [VW-1:0] V_LAST        = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST    = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_START  = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END    = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [1:0] DT_GUARD = 2'b00;
    localparam logic [1:0] DT_CTRL  = 2'b01;
    localparam logic [1:0] DT_PIXEL = 2'b11;

    localparam logic [1:0] SLOT_BLANK = 2'd0;
    localparam logic [1:0] SLOT_PIXEL = 2'd1;
    localparam logic [1:0] SLOT_PRE   = 2'd2;
    localparam logic [1:0] SLOT_GUARD = 2'd3;

    generate
        if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_region
            $error("hdmi_framer: every timing region needs at least one clock or line");
        end
        if (HDMI_MODE && H_BACK < 10) begin : g_bad_back
            $error("hdmi_framer: back porch too short for preamble plus guard band");
        end
    endgenerate

    logic [HW-1:0] h_r;
    logic [VW-1:0] v_r;
    logic          h_act_s;
    logic          v_act_s;
    logic          h_sync_s;
    logic          v_sync_s;
    logic          next_act_s;
    logic [1:0]    ctl0_s;
    logic [1:0]    slot_s;

    logic [1:0]    dtype_r;
    logic [1:0]    ctl0_r;
    logic [1:0]    ctl1_r;
    logic [1:0]    ctl2_r;
    logic [23:0]   data_r;
    logic          frame_start_r;
    logic          underflow_r;

    // Raster counters; parked at the origin while disabled so a run always opens on a pixel.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_r <= H_ZERO;
            v_r <= V_ZERO;
        end else if (!i_en) begin
            h_r <= H_ZERO;
            v_r <= V_ZERO;
        end else if (h_r == H_LAST) begin
            h_r <= H_ZERO;
            v_r <= (v_r == V_LAST) ? V_ZERO : (v_r + V_ONE);
        end else begin
            h_r <= h_r + H_ONE;
        end
    end

    assign h_act_s    = (h_r < H_ACT_END);
    assign v_act_s    = (v_r < V_ACT_END);
    assign h_sync_s   = (h_r >= H_SYNC_START) && (h_r < H_SYNC_END);
    assign v_sync_s   = (v_r >= V_SYNC_START) && (v_r < V_SYNC_END);
    // The last vertical blank line also precedes an active line (the next frame's first).
    assign next_act_s = (v_r < V_ACT_LAST) || (v_r == V_LAST);
    assign ctl0_s     = {v_sync_s ? VSYNC_POL : ~VSYNC_POL, h_sync_s ? HSYNC_POL : ~HSYNC_POL};
    assign o_pix_ready = i_en && h_act_s && v_act_s;

    // Classify the current slot; preamble and guard only exist in HDMI mode.
    always_comb begin
        slot_s = SLOT_BLANK;
        if (!i_en) begin
            slot_s = SLOT_BLANK;
        end else if (h_act_s && v_act_s) begin
            slot_s = SLOT_PIXEL;
        end else if (HDMI_MODE && next_act_s && (h_r >= H_PRE_START)) begin
            slot_s = (h_r >= H_GUARD_START) ? SLOT_GUARD : SLOT_PRE;
        end else begin
            slot_s = SLOT_BLANK;
        end
    end

    // Channel output register, one cycle behind the counters, plus sticky underflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dtype_r       <= DT_CTRL;
            ctl0_r        <= {~VSYNC_POL, ~HSYNC_POL};
            ctl1_r        <= 2'b00;
            ctl2_r        <= 2'b00;
            data_r        <= 24'h000000;
            frame_start_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            frame_start_r <= i_en && (h_r == H_ZERO) && (v_r == V_ZERO);
            if (o_pix_ready && !i_pix_valid) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
            ctl0_r <= ctl0_s;
            ctl2_r <= 2'b00;
            case (slot_s)
                SLOT_PIXEL: begin
                    dtype_r <= DT_PIXEL;
                    ctl1_r  <= 2'b00;
                    data_r  <= i_pix_valid ? i_pix : 24'h000000;
                end
                SLOT_PRE: begin
                    dtype_r <= DT_CTRL;
                    ctl1_r  <= 2'b01;
                    data_r  <= 24'h000000;
                end
                SLOT_GUARD: begin
                    dtype_r <= DT_GUARD;
                    ctl1_r  <= 2'b00;
                    data_r  <= 24'h000000;
                end
                default: begin
                    dtype_r <= DT_CTRL;
                    ctl1_r  <= 2'b00;
                    data_r  <= 24'h000000;
                end
            endcase
        end
    end

    assign o_dtype0      = dtype_r;
    assign o_dtype1      = dtype_r;
    assign o_dtype2      = dtype_r;
    assign o_ctl0        = ctl0_r;
    assign o_ctl1        = ctl1_r;
    assign o_ctl2        = ctl2_r;
    assign o_data0       = data_r[7:0];
    assign o_data1       = data_r[15:8];
    assign o_data2       = data_r[23:16];
    assign o_aux0        = 4'h0;
    assign o_aux1        = 4'h0;
    assign o_aux2        = 4'h0;
    assign o_frame_start = frame_start_r;
    assign o_underflow   = underflow_r;

endmodule
